// File: rtl/pc_stack_unit_if.sv
// Control-side bundle for pc_stack_unit. The control unit issues ops through it and
// reads back PC, stack status and error flags.
interface pc_stack_unit_if #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4,
  parameter int OFF_WIDTH   = 8
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic                 EscPC;
  logic [2:0]           op;
  logic [WIDTH-1:0]     target;
  logic [OFF_WIDTH-1:0] offset;
  logic                 clr_err;

  logic [WIDTH-1:0]     pc_out;
  logic [WIDTH-1:0]     tos;
  logic [DW-1:0]        depth;
  logic                 stack_full;
  logic                 stack_empty;
  logic                 ovf_err;
  logic                 unf_err;
  logic                 op_err;

  modport master (
    output EscPC, op, target, offset, clr_err,
    input  pc_out, tos, depth, stack_full, stack_empty, ovf_err, unf_err, op_err
  );

  modport slave (
    input  EscPC, op, target, offset, clr_err,
    output pc_out, tos, depth, stack_full, stack_empty, ovf_err, unf_err, op_err
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a return-address stack: increment, relative branch, jump,
// call and return, with sticky overflow/underflow/reserved-op error flags.
module pc_stack_unit #(
  parameter int               WIDTH        = 8,
  parameter int               STACK_DEPTH  = 4,
  parameter int               OFF_WIDTH    = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  pc_stack_unit_if.slave    bus
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  typedef enum logic [2:0] {
    OP_INC    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4
  } op_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [WIDTH-1:0] stack_d [STACK_DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             operr_q, operr_d;
  logic             full, empty;
  logic [WIDTH-1:0] pc_inc;

  function automatic logic [WIDTH-1:0] sext_off(input logic signed [OFF_WIDTH-1:0] off);
    return WIDTH'(off);
  endfunction

  assign full   = (depth_q == DW'(STACK_DEPTH));
  assign empty  = (depth_q == '0);
  assign pc_inc = pc_q + WIDTH'(1);

  // Stack is kept as a shift register with the top at index 0; pops shift zeros in
  // from the bottom, so entry 0 already reads 0 whenever the stack is empty.
  always_comb begin
    pc_d    = pc_q;
    stack_d = stack_q;
    depth_d = depth_q;
    ovf_d   = bus.clr_err ? 1'b0 : ovf_q;
    unf_d   = bus.clr_err ? 1'b0 : unf_q;
    operr_d = bus.clr_err ? 1'b0 : operr_q;

    if (bus.EscPC) begin
      case (bus.op)
        OP_INC:    pc_d = pc_inc;
        OP_BRANCH: pc_d = pc_q + sext_off(bus.offset);
        OP_JUMP:   pc_d = bus.target;
        OP_CALL: begin
          pc_d = bus.target;
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            stack_d[0] = pc_inc;
            for (int i = 1; i < STACK_DEPTH; i++) stack_d[i] = stack_q[i-1];
            depth_d = depth_q + DW'(1);
          end
        end
        OP_RET: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            pc_d = stack_q[0];
            for (int i = 0; i < STACK_DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
            stack_d[STACK_DEPTH-1] = '0;
            depth_d = depth_q - DW'(1);
          end
        end
        default:   operr_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      operr_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      operr_q <= operr_d;
      stack_q <= stack_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.tos         = stack_q[0];
  assign bus.depth       = depth_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.ovf_err     = ovf_q;
  assign bus.unf_err     = unf_q;
  assign bus.op_err      = operr_q;
endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program counter with an integrated return-address stack. Successor to the fixed 8-bit load-only PC.
- Each enabled cycle it supports increment, relative branch, absolute jump, call and return.
- Sits between the control unit (supplies `op` and `EscPC`) and instruction memory (consumes `pc_out`).
- Reports stack depth and sticky overflow/underflow errors to the control unit.

Parameters:
- WIDTH, 8, bit width of the PC and of all addresses.
- STACK_DEPTH, 4, number of return-address entries (>=1).
- OFF_WIDTH, 8, bit width of the signed branch offset (<= WIDTH).
- RESET_VECTOR, 0, PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- EscPC  in  1  PC update enable; 0 = stall, nothing changes.
- op  in  3  operation: 0 INC, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5-7 reserved.
- target  in  WIDTH  absolute address for JUMP/CALL.
- offset  in  OFF_WIDTH  two's-complement offset for BRANCH.
- clr_err  in  1  clears sticky error flags.
- pc_out  out  WIDTH  current PC, registered.
- tos  out  WIDTH  top-of-stack return address; 0 when empty.
- depth  out  clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  out  1  depth == STACK_DEPTH.
- stack_empty  out  1  depth == 0.
- ovf_err  out  1  sticky: CALL attempted while full.
- unf_err  out  1  sticky: RET attempted while empty.
- op_err  out  1  sticky: reserved op issued while enabled.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - pc_out=RESET_VECTOR, depth=0, all stack entries=0, tos=0.
  - ovf_err, unf_err and op_err all 0.
  - reset has priority over every other input.
- Latency: the new PC is visible on pc_out one cycle after the enabled edge. All outputs are registered or derived from registers only; there are no combinational input-to-output paths.
- EscPC=0: pc_out, stack, depth and error flags hold. clr_err still acts.
- All PC arithmetic is modulo 2^WIDTH; wrap-around is silent, with no flag.
- INC: pc <= pc+1.
- BRANCH: pc <= pc + sign_extend(offset). offset=0 keeps pc.
- JUMP: pc <= target.
- CALL:
  - Not full: push pc+1 (wrapped), depth+1, pc <= target.
  - Full: pc <= target, push discarded, stack unchanged, ovf_err<=1.
- RET:
  - Not empty: pc <= tos, pop, depth-1.
  - Empty: pc holds, unf_err<=1.
- Reserved op (5-7) with EscPC=1: pc holds, stack unchanged, op_err<=1.
- Stack is LIFO. tos always reflects the most recently pushed valid entry. Popped entries need not be cleared.
- clr_err=1 clears all three sticky flags at the edge. If an error condition occurs in the same cycle, set wins and the flag reads 1.
- Reset asserted mid-sequence (e.g. with nested calls pending) discards the entire stack. No partial state survives.
- Only one operation is performed per cycle. Push and pop never occur in the same cycle.

Test Plan:
- WIDTH=8: reset, then 3 cycles of INC with EscPC=1 -> pc_out 0,1,2,3. Deassert EscPC for 2 cycles -> pc_out stays 3, depth 0.
- pc=0xFE, INC twice -> 0xFF, then 0x00. BRANCH offset=0xFC (-4) from 0x10 -> 0x0C. BRANCH offset=0x05 from 0xFD -> 0x02.
- STACK_DEPTH=4: CALL target=0x40 from pc=0x10 -> pc 0x40, tos 0x11, depth 1. Nest 3 more CALLs -> stack_full=1.
  - A 5th CALL to 0x80 -> pc 0x80, ovf_err=1, depth 4, tos unchanged.
  - 4 RETs return addresses in reverse push order; stack_empty=1 afterwards.
- RET with empty stack at pc=0x22 -> pc stays 0x22, unf_err=1. op=6 -> op_err=1, pc stays 0x22.
  - clr_err pulse -> all flags 0.
  - clr_err asserted together with a RET-on-empty -> unf_err stays 1.
- Two nested CALLs (depth 2), then reset during a cycle where op=RET -> pc_out=RESET_VECTOR, depth 0, tos 0, flags 0 on the next cycle.
